// File: rtl/usadd_uni_param.sv
// -----------------------------------------------------------------------------
// usadd_uni_param -- parametrised unipolar stochastic adder
//
// Each enabled cycle the NUM_IN input bitstream bits are popcounted and added
// to an accumulator. One output bitstream is produced:
//   iMode = 0 : scaled add. out carries the mean density of the inputs.
//               One output 1 is emitted per NUM_IN accumulated input 1s.
//   iMode = 1 : saturating unscaled add. Every accumulated input 1 becomes an
//               output 1. Excess 1s are banked in acc and drained one per
//               cycle. The bank clamps at 2^ACC_W-1.
//
// Parameters
//   NUM_IN  number of input bitstreams (>= 2)
//   ACC_W   accumulator width; 2^ACC_W must exceed 2*NUM_IN
//   CNT_W   width of the optional ones counter
//
// Ports
//   iClk     rising-edge clock
//   iRstN    asynchronous active-low reset
//   iEn      advance enable; when low the state holds and out emits 0
//   iClr     synchronous clear of acc/out (and ones counter); beats iEn
//   iMode    0 = scaled add, 1 = saturating add
//   in       NUM_IN input bitstream bits
//   out      registered output bit; reflects in/iMode from the previous edge
//   oOneCnt  count of 1s loaded into out (only with USADD_ONECNT_EN)
//
// Optional feature macro: USADD_ONECNT_EN adds the saturating ones counter
// and the oOneCnt port. out behaves identically in both builds.
// -----------------------------------------------------------------------------
module usadd_uni_param #(
  parameter int NUM_IN = 16,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic              iClr,
  input  logic              iMode,
  input  logic [NUM_IN-1:0] in,
`ifdef USADD_ONECNT_EN
  output logic              out,
  output logic [CNT_W-1:0]  oOneCnt
`else
  output logic              out
`endif
);

  localparam int PC_W = $clog2(NUM_IN + 1);
  localparam logic [ACC_W:0] NUM_IN_W = (ACC_W + 1)'(NUM_IN);
  localparam logic [ACC_W:0] ACC_MAX  = {1'b0, {ACC_W{1'b1}}};
  localparam logic [ACC_W:0] ONE_W    = (ACC_W + 1)'(1);

  // The accumulator has to hold acc + popcount without ambiguity in both
  // modes, so the width must clear 2*NUM_IN.
  if (NUM_IN < 2) begin : g_bad_num_in
    $error("usadd_uni_param: NUM_IN must be at least 2");
  end
  if (ACC_W < 31 && (64'(1) << ACC_W) <= 64'(2 * NUM_IN)) begin : g_bad_acc_w
    $error("usadd_uni_param: ACC_W too small, need 2^ACC_W > 2*NUM_IN");
  end

  logic [ACC_W-1:0] acc;
  logic             mode_q;

  logic [PC_W-1:0]  pc;
  logic [ACC_W-1:0] acc_eff;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   sum_m1;
  logic [ACC_W-1:0] acc_nxt;
  logic             out_nxt;

  // Popcount of the input channels.
  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pc = pc + PC_W'(in[i]);
    end
  end

  // Next-state datapath. A mode change discards the residue left by the
  // previous mode, so the old acc is replaced by 0 for this cycle's sum.
  always_comb begin
    acc_eff = (iMode != mode_q) ? '0 : acc;
    sum     = {1'b0, acc_eff} + (ACC_W + 1)'(pc);
    sum_m1  = sum - ONE_W;
    acc_nxt = acc;
    out_nxt = 1'b0;
    if (!iMode) begin
      if (sum >= NUM_IN_W) begin
        out_nxt = 1'b1;
        acc_nxt = ACC_W'(sum - NUM_IN_W);
      end else begin
        acc_nxt = sum[ACC_W-1:0];
      end
    end else begin
      if (sum != '0) begin
        out_nxt = 1'b1;
        // Bank clamps at full scale instead of wrapping.
        acc_nxt = (sum_m1 > ACC_MAX) ? '1 : sum_m1[ACC_W-1:0];
      end else begin
        acc_nxt = '0;
      end
    end
  end

  // Control priority: reset, then clear, then enable. A stalled stream
  // emits 0s while acc and mode_q hold.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      acc    <= '0;
      out    <= 1'b0;
      mode_q <= 1'b0;
    end else if (iClr) begin
      acc    <= '0;
      out    <= 1'b0;
      mode_q <= iMode;
    end else if (iEn) begin
      acc    <= acc_nxt;
      out    <= out_nxt;
      mode_q <= iMode;
    end else begin
      out    <= 1'b0;
    end
  end

`ifdef USADD_ONECNT_EN
  // Counts every edge on which out is loaded with 1; saturates at all-ones.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oOneCnt <= '0;
    end else if (iClr) begin
      oOneCnt <= '0;
    end else if (iEn && out_nxt && (oOneCnt != '1)) begin
      oOneCnt <= oOneCnt + CNT_W'(1);
    end
  end
`endif

endmodule
